alu_cmd_ctrl: RTL

Command-side controller for the ALU in the multi-clock communication system. It parses ALU command frames arriving as bytes from the UART receive path and drives the ALU operands, function and enable. It gates the ALU clock only around an operation, captures the registered 16-bit result, and returns it to the UART transmit path as two bytes, low byte first. It sits in the reference-clock domain between the RX/TX synchronised byte interfaces and the ALU.

---
 rtl/alu_ctrl_pkg.sv | 45 ++++
 rtl/alu_result_sender.sv | 58 +++++
 rtl/alu_cmd_ctrl.sv | 128 ++++++++++++
 3 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared constants and state encodings for the ALU command controller.
// Covers frame command bytes, ALU function codes and the controller/sender FSM states.
package alu_ctrl_pkg;

    localparam int FUN_WIDTH = 4;

    localparam logic [7:0] CMD_ALU_OPER = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOP  = 8'hDD;

    localparam logic [FUN_WIDTH-1:0] ALU_ADD    = 4'd0;
    localparam logic [FUN_WIDTH-1:0] ALU_SUB    = 4'd1;
    localparam logic [FUN_WIDTH-1:0] ALU_MUL    = 4'd2;
    localparam logic [FUN_WIDTH-1:0] ALU_DIV    = 4'd3;
    localparam logic [FUN_WIDTH-1:0] ALU_AND    = 4'd4;
    localparam logic [FUN_WIDTH-1:0] ALU_OR     = 4'd5;
    localparam logic [FUN_WIDTH-1:0] ALU_NAND   = 4'd6;
    localparam logic [FUN_WIDTH-1:0] ALU_NOR    = 4'd7;
    localparam logic [FUN_WIDTH-1:0] ALU_XOR    = 4'd8;
    localparam logic [FUN_WIDTH-1:0] ALU_XNOR   = 4'd9;
    localparam logic [FUN_WIDTH-1:0] ALU_CMP_EQ = 4'd10;
    localparam logic [FUN_WIDTH-1:0] ALU_CMP_GT = 4'd11;
    localparam logic [FUN_WIDTH-1:0] ALU_CMP_LT = 4'd12;
    localparam logic [FUN_WIDTH-1:0] ALU_SHR    = 4'd13;
    localparam logic [FUN_WIDTH-1:0] ALU_SHL    = 4'd14;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_GET_A,
        ST_GET_B,
        ST_GET_FUN,
        ST_GATE_ON,
        ST_ALU_REQ,
        ST_ALU_WAIT,
        ST_SEND_LO,
        ST_SEND_HI
    } ctrl_state_e;

    typedef enum logic [1:0] {
        SND_IDLE,
        SND_LO,
        SND_GAP,
        SND_HI
    } snd_state_e;

endpackage

// File: rtl/alu_result_sender.sv
// Two-byte result serializer, low byte first; tx_vld rises the cycle after load.
// Holds each byte until a cycle with tx_busy low, then idles until tx_busy is seen low again.
module alu_result_sender
    import alu_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [2*DATA_WIDTH-1:0] data,
    input  logic                    tx_busy,
    output logic [DATA_WIDTH-1:0]   tx_dat,
    output logic                    tx_vld,
    output logic                    lo_sent,
    output logic                    hi_sent
);

    snd_state_e state;
    logic       sel_hi;

    // data is the caller's result register, stable for the whole transfer
    assign tx_dat  = sel_hi ? data[2*DATA_WIDTH-1:DATA_WIDTH] : data[DATA_WIDTH-1:0];
    assign lo_sent = (state == SND_LO) && !tx_busy;
    assign hi_sent = (state == SND_HI) && !tx_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= SND_IDLE;
            tx_vld <= 1'b0;
            sel_hi <= 1'b0;
        end else begin
            case (state)
                SND_IDLE: if (load) begin
                    tx_vld <= 1'b1;
                    sel_hi <= 1'b0;
                    state  <= SND_LO;
                end
                SND_LO: if (!tx_busy) begin
                    tx_vld <= 1'b0;
                    state  <= SND_GAP;
                end
                // The transmitter raises busy one cycle after accepting, so wait for it to clear
                SND_GAP: if (!tx_busy) begin
                    tx_vld <= 1'b1;
                    sel_hi <= 1'b1;
                    state  <= SND_HI;
                end
                SND_HI: if (!tx_busy) begin
                    tx_vld <= 1'b0;
                    state  <= SND_IDLE;
                end
                default: state <= SND_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/alu_cmd_ctrl.sv
// ALU command controller: parses 0xCC/0xDD frames, gates and enables the ALU, returns the result as two bytes.
// FUN strobe to ALU_EN is 2 cycles; TX stalls on TX_BUSY. ALU_TIMEOUT_EN adds a result-wait timeout.
module alu_cmd_ctrl #(
    parameter int DATA_WIDTH  = 8,
    parameter int FUN_WIDTH   = 4,
    parameter int ALU_TIMEOUT = 4
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
    input  logic                    RX_D_VLD,
    input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
    input  logic                    OUT_VALID,
    input  logic                    TX_BUSY,
    output logic [DATA_WIDTH-1:0]   A,
    output logic [DATA_WIDTH-1:0]   B,
    output logic [FUN_WIDTH-1:0]    ALU_FUN,
    output logic                    ALU_EN,
    output logic                    CLK_GATE_EN,
    output logic [DATA_WIDTH-1:0]   TX_P_DATA,
    output logic                    TX_D_VLD,
    output logic                    FRAME_ERR
);
    import alu_ctrl_pkg::*;

    ctrl_state_e             state;
    logic [2*DATA_WIDTH-1:0] result;
    logic                    snd_load;
    logic                    lo_sent;
    logic                    hi_sent;

    // The wait counter is preloaded to 1 in ALU_REQ, so fewer than 2 cycles cannot be expressed
    if (ALU_TIMEOUT < 2) begin : g_timeout_range
        $error("ALU_TIMEOUT must be at least 2");
    end

`ifdef ALU_TIMEOUT_EN
    localparam int CNT_W = $clog2(ALU_TIMEOUT + 1);
    logic [CNT_W-1:0] wait_cnt;
`endif

    assign snd_load = (state == ST_ALU_WAIT) && OUT_VALID;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state       <= ST_IDLE;
            A           <= '0;
            B           <= '0;
            ALU_FUN     <= '0;
            result      <= '0;
            ALU_EN      <= 1'b0;
            CLK_GATE_EN <= 1'b0;
            FRAME_ERR   <= 1'b0;
`ifdef ALU_TIMEOUT_EN
            wait_cnt    <= '0;
`endif
        end else begin
            ALU_EN    <= 1'b0;
            FRAME_ERR <= 1'b0;
            case (state)
                ST_IDLE: if (RX_D_VLD) begin
                    if (RX_P_DATA == CMD_ALU_OPER)
                        state <= ST_GET_A;
                    else if (RX_P_DATA == CMD_ALU_NOP)
                        state <= ST_GET_FUN;
                    else
                        FRAME_ERR <= 1'b1;
                end
                ST_GET_A: if (RX_D_VLD) begin
                    A     <= RX_P_DATA;
                    state <= ST_GET_B;
                end
                ST_GET_B: if (RX_D_VLD) begin
                    B     <= RX_P_DATA;
                    state <= ST_GET_FUN;
                end
                ST_GET_FUN: if (RX_D_VLD) begin
                    ALU_FUN     <= RX_P_DATA[FUN_WIDTH-1:0];
                    CLK_GATE_EN <= 1'b1;
                    state       <= ST_GATE_ON;
                end
                ST_GATE_ON: begin
                    ALU_EN <= 1'b1;
                    state  <= ST_ALU_REQ;
                end
                ST_ALU_REQ: begin
`ifdef ALU_TIMEOUT_EN
                    // Counts cycles since ALU_EN so the error lands ALU_TIMEOUT cycles after it
                    wait_cnt <= CNT_W'(1);
`endif
                    state <= ST_ALU_WAIT;
                end
                ST_ALU_WAIT: if (OUT_VALID) begin
                    result      <= ALU_OUT;
                    CLK_GATE_EN <= 1'b0;
                    state       <= ST_SEND_LO;
                end
`ifdef ALU_TIMEOUT_EN
                else if (wait_cnt == CNT_W'(ALU_TIMEOUT - 1)) begin
                    FRAME_ERR   <= 1'b1;
                    CLK_GATE_EN <= 1'b0;
                    state       <= ST_IDLE;
                end else begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
`endif
                ST_SEND_LO: if (lo_sent) state <= ST_SEND_HI;
                ST_SEND_HI: if (hi_sent) state <= ST_IDLE;
                default:    state <= ST_IDLE;
            endcase
        end
    end

    alu_result_sender #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_sender (
        .clk     (CLK),
        .rst_n   (RST),
        .load    (snd_load),
        .data    (result),
        .tx_busy (TX_BUSY),
        .tx_dat  (TX_P_DATA),
        .tx_vld  (TX_D_VLD),
        .lo_sent (lo_sent),
        .hi_sent (hi_sent)
    );

endmodule
